// File: rtl/ysyx_23060096_pkg.sv
// Shared types and constants for the ysyx_23060096 instruction fetch unit.
package ysyx_23060096_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_VALID = 2'd3
  } ifu_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  // addi x0, x0, 0; reserved for bubble insertion once the core is pipelined
  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/ysyx_23060096_ifu_if.sv
// Instruction-memory port and core-facing fetch port of the IFU.
interface ysyx_23060096_ifu_if #(
  parameter int CNT_W = 64
);

  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [31:0]      imem_req_addr;
  logic             imem_rsp_valid;
  logic             imem_rsp_ready;
  logic [31:0]      imem_rsp_data;
  logic             imem_rsp_err;
  logic             inst_valid;
  logic             inst_ready;
  logic [31:0]      inst;
  logic [31:0]      pc;
  logic             inst_err;
  logic [31:0]      dnpc;
  logic [CNT_W-1:0] fetch_cnt;

  modport master (
    output imem_req_valid, imem_req_addr, imem_rsp_ready,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output inst_valid, inst, pc, inst_err, fetch_cnt,
    input  inst_ready, dnpc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, imem_rsp_ready,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  inst_valid, inst, pc, inst_err, fetch_cnt,
    output inst_ready, dnpc
  );

endinterface

// File: rtl/ysyx_23060096_ifu.sv
// Instruction fetch unit: owns the PC, issues one imem read at a time and
// hands each fetched word to the core over a valid/ready handshake.
module ysyx_23060096_ifu
  import ysyx_23060096_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 64
) (
  input  logic                clk,
  input  logic                rst,
  ysyx_23060096_ifu_if.master bus
);

  ifu_state_e       r_state;
  ifu_state_e       w_state_nxt;
  logic [31:0]      r_pc;
  logic [31:0]      r_inst;
  logic             r_inst_err;
  logic [CNT_W-1:0] r_fetch_cnt;

  logic w_misaligned;
  logic w_accept;
  logic w_req_valid;
  logic w_rsp_ready;
  logic w_inst_valid;

  assign w_misaligned = (r_pc[1:0] != 2'b00);
  assign w_accept     = (r_state == S_VALID) && bus.inst_ready;

  // Outputs depend on state and the registered PC only, never on inputs
  always_comb begin
    w_state_nxt  = r_state;
    w_req_valid  = 1'b0;
    w_rsp_ready  = 1'b0;
    w_inst_valid = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        w_req_valid = !w_misaligned;
        if (w_misaligned)           w_state_nxt = S_VALID;
        else if (bus.imem_req_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_rsp_ready = 1'b1;
        if (bus.imem_rsp_valid) w_state_nxt = S_VALID;
      end
      S_VALID: begin
        w_inst_valid = 1'b1;
        if (bus.inst_ready) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_inst      <= 32'h0;
      r_inst_err  <= 1'b0;
      r_fetch_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_REQ) && w_misaligned) begin
        r_inst     <= 32'h0;
        r_inst_err <= 1'b1;
      end else if ((r_state == S_WAIT) && bus.imem_rsp_valid) begin
        r_inst     <= bus.imem_rsp_data;
        r_inst_err <= bus.imem_rsp_err;
      end
      if (w_accept) begin
        r_pc        <= bus.dnpc;
        r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.imem_rsp_ready = w_rsp_ready;
  assign bus.inst_valid     = w_inst_valid;
  assign bus.inst           = r_inst;
  assign bus.pc             = r_pc;
  assign bus.inst_err       = r_inst_err;
  assign bus.fetch_cnt      = r_fetch_cnt;

endmodule

// File: tb/tb_ysyx_23060096_ifu.sv
// Self-checking bench for the IFU: directed scenarios plus a randomized run
// scored against a transaction-level fetch model.
module tb_ysyx_23060096_ifu;
  import ysyx_23060096_pkg::*;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ysyx_23060096_ifu_if #(.CNT_W(64)) bus();

  ysyx_23060096_ifu #(.RESET_PC(RPC), .CNT_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          req_pct = 100;
  int          rsp_pct = 100;
  bit          mem_nop = 1'b0;
  bit          mem_pending = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  int          req_count = 0;
  int          proto_viol = 0;

  // Memory contents and fault map as pure functions of the address
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h3C5A_9617;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return a[7:4] == 4'h1;
  endfunction

  // One clock: drive the memory side, note handshakes, advance past the edge
  task automatic cyc();
    logic        rf, sf;
    logic [31:0] ra;
    bus.imem_req_ready = (int'($urandom_range(99)) < req_pct);
    if (mem_pending && (int'($urandom_range(99)) < rsp_pct)) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_nop ? NOP : mem_data(mem_addr);
      bus.imem_rsp_err   = mem_nop ? 1'b0 : mem_err(mem_addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
      bus.imem_rsp_err   = 1'($urandom_range(1));
    end
    if (bus.imem_rsp_valid && !bus.imem_rsp_ready) proto_viol++;
    rf = bus.imem_req_valid && bus.imem_req_ready;
    sf = bus.imem_rsp_valid && bus.imem_rsp_ready;
    ra = bus.imem_req_addr;
    @(posedge clk);
    #1;
    if (sf) mem_pending = 1'b0;
    if (rf) begin
      mem_pending = 1'b1;
      mem_addr    = ra;
      req_count++;
    end
  endtask

  task automatic idle_inputs();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.imem_rsp_err   = 1'b0;
    bus.inst_ready     = 1'b0;
    bus.dnpc           = 32'h0;
  endtask

  // Leaves the bench at the sample point of the IDLE cycle after reset release
  task automatic reset_dut();
    @(posedge clk);
    #2;
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_pending = 1'b0;
  endtask

  task automatic run_to_valid();
    for (int i = 0; i < 60 && !bus.inst_valid; i++) cyc();
    n_vec++;
    if (bus.inst_valid !== 1'b1) begin
      n_err++;
      $display("FAIL run_to_valid: inst_valid=%b after 60 cycles, required 1", bus.inst_valid);
    end
  endtask

  task automatic test_reset();
    logic [130:0] got, exp;
    idle_inputs();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    got = {bus.imem_req_valid, bus.imem_rsp_ready, bus.inst_valid, bus.inst_err,
           bus.pc, bus.inst, bus.fetch_cnt};
    exp = {4'b0000, RPC, 32'h0, 64'h0};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL reset_values: got %h required %h", got, exp);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_vec++;
    if ({bus.imem_req_valid, bus.inst_valid, bus.imem_rsp_ready} !== 3'b000) begin
      n_err++;
      $display("FAIL idle_cycle1: req/inst/rsp_ready=%b required 000",
               {bus.imem_req_valid, bus.inst_valid, bus.imem_rsp_ready});
    end
    cyc();
    n_vec++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RPC) begin
      n_err++;
      $display("FAIL first_req_cycle2: valid=%b addr=%h required 1 %h",
               bus.imem_req_valid, bus.imem_req_addr, RPC);
    end
  endtask

  task automatic test_zero_wait();
    logic        exp_v, exp_r;
    logic [31:0] exp_a;
    reset_dut();
    mem_nop = 1'b1;
    req_pct = 100;
    rsp_pct = 100;
    bus.inst_ready = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      bus.dnpc = RPC + 32'(4 * ((c - 1) / 3));
      exp_r = (c % 3 == 2);
      exp_a = RPC + 32'(4 * ((c - 2) / 3));
      exp_v = (c >= 4) && (c <= 10) && ((c - 4) % 3 == 0);
      n_vec++;
      if (bus.imem_req_valid !== exp_r || (exp_r && bus.imem_req_addr !== exp_a)) begin
        n_err++;
        $display("FAIL zw_req c%0d: valid=%b addr=%h required %b %h",
                 c, bus.imem_req_valid, bus.imem_req_addr, exp_r, exp_a);
      end
      n_vec++;
      if (bus.inst_valid !== exp_v ||
          (exp_v && (bus.pc !== RPC + 32'(4 * ((c - 4) / 3)) || bus.inst !== NOP))) begin
        n_err++;
        $display("FAIL zw_inst c%0d: valid=%b pc=%h inst=%h required valid %b",
                 c, bus.inst_valid, bus.pc, bus.inst, exp_v);
      end
      if (c < 11) cyc();
    end
    n_vec++;
    if (bus.fetch_cnt !== 64'd3) begin
      n_err++;
      $display("FAIL zw_fetch_cnt: got %0d required 3", bus.fetch_cnt);
    end
    mem_nop = 1'b0;
    bus.inst_ready = 1'b0;
  endtask

  task automatic test_req_stall();
    reset_dut();
    req_pct = 0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RPC || bus.imem_rsp_ready !== 1'b0) begin
        n_err++;
        $display("FAIL req_stall %0d: valid=%b addr=%h rsp_ready=%b required 1 %h 0",
                 i, bus.imem_req_valid, bus.imem_req_addr, bus.imem_rsp_ready, RPC);
      end
      cyc();
    end
    req_pct = 100;
    rsp_pct = 0;
    cyc();
    n_vec++;
    if (bus.imem_rsp_ready !== 1'b1 || bus.imem_req_valid !== 1'b0 || req_count == 0 || !mem_pending) begin
      n_err++;
      $display("FAIL req_stall_wait: rsp_ready=%b req_valid=%b required 1 0",
               bus.imem_rsp_ready, bus.imem_req_valid);
    end
  endtask

  task automatic test_inst_stall();
    logic [64:0] exp;
    rsp_pct = 100;
    bus.inst_ready = 1'b0;
    cyc();
    exp = {RPC, mem_data(RPC), mem_err(RPC)};
    for (int i = 0; i < 4; i++) begin
      bus.dnpc = $urandom;
      n_vec++;
      if (bus.inst_valid !== 1'b1 || {bus.pc, bus.inst, bus.inst_err} !== exp || bus.imem_req_valid !== 1'b0) begin
        n_err++;
        $display("FAIL inst_stall %0d: valid=%b pc/inst/err=%h req=%b required 1 %h 0",
                 i, bus.inst_valid, {bus.pc, bus.inst, bus.inst_err}, bus.imem_req_valid, exp);
      end
      cyc();
    end
    bus.inst_ready = 1'b1;
    bus.dnpc = RPC + 32'h40;
    cyc();
    bus.inst_ready = 1'b0;
    bus.dnpc = $urandom;
    n_vec++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RPC + 32'h40 || bus.fetch_cnt !== 64'd1) begin
      n_err++;
      $display("FAIL inst_stall_accept: req=%b addr=%h cnt=%0d required 1 %h 1",
               bus.imem_req_valid, bus.imem_req_addr, bus.fetch_cnt, RPC + 32'h40);
    end
  endtask

  task automatic test_err_rsp();
    reset_dut();
    req_pct = 100;
    rsp_pct = 100;
    run_to_valid();
    bus.dnpc = RPC + 32'h10;
    bus.inst_ready = 1'b1;
    cyc();
    bus.inst_ready = 1'b0;
    run_to_valid();
    n_vec++;
    if (bus.pc !== RPC + 32'h10 || bus.inst_err !== 1'b1 || bus.inst !== mem_data(RPC + 32'h10)) begin
      n_err++;
      $display("FAIL err_rsp: pc=%h err=%b inst=%h required %h 1 %h",
               bus.pc, bus.inst_err, bus.inst, RPC + 32'h10, mem_data(RPC + 32'h10));
    end
    bus.dnpc = RPC + 32'h100;
    bus.inst_ready = 1'b1;
    cyc();
    bus.inst_ready = 1'b0;
    run_to_valid();
    n_vec++;
    if (bus.pc !== RPC + 32'h100 || bus.inst_err !== 1'b0 || bus.inst !== mem_data(RPC + 32'h100)) begin
      n_err++;
      $display("FAIL err_clear: pc=%h err=%b inst=%h required %h 0 %h",
               bus.pc, bus.inst_err, bus.inst, RPC + 32'h100, mem_data(RPC + 32'h100));
    end
  endtask

  task automatic test_misaligned();
    int rc;
    rc = req_count;
    bus.dnpc = RPC + 32'h102;
    bus.inst_ready = 1'b1;
    cyc();
    bus.inst_ready = 1'b0;
    n_vec++;
    if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin
      n_err++;
      $display("FAIL misaligned_req: req=%b inst_valid=%b required 0 0", bus.imem_req_valid, bus.inst_valid);
    end
    cyc();
    n_vec++;
    if (bus.inst_valid !== 1'b1 || bus.inst_err !== 1'b1 || bus.inst !== 32'h0 ||
        bus.pc !== RPC + 32'h102 || req_count != rc) begin
      n_err++;
      $display("FAIL misaligned_valid: valid=%b err=%b inst=%h pc=%h reqs=%0d required 1 1 0 %h 0",
               bus.inst_valid, bus.inst_err, bus.inst, bus.pc, req_count - rc, RPC + 32'h102);
    end
    bus.dnpc = RPC + 32'h20;
    bus.inst_ready = 1'b1;
    cyc();
    bus.inst_ready = 1'b0;
    n_vec++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RPC + 32'h20) begin
      n_err++;
      $display("FAIL misaligned_recover: req=%b addr=%h required 1 %h",
               bus.imem_req_valid, bus.imem_req_addr, RPC + 32'h20);
    end
  endtask

  task automatic test_reset_mid();
    logic [130:0] got, exp;
    reset_dut();
    req_pct = 100;
    rsp_pct = 100;
    bus.inst_ready = 1'b1;
    bus.dnpc = RPC + 32'h4;
    for (int i = 0; i < 7; i++) cyc();
    rsp_pct = 0;
    for (int i = 0; i < 10 && !bus.imem_rsp_ready; i++) cyc();
    n_vec++;
    if (bus.imem_rsp_ready !== 1'b1 || bus.fetch_cnt !== 64'd2) begin
      n_err++;
      $display("FAIL mid_pre_wait: rsp_ready=%b cnt=%0d required 1 2", bus.imem_rsp_ready, bus.fetch_cnt);
    end
    #2;
    rst = 1'b1;
    #1;
    got = {bus.imem_req_valid, bus.imem_rsp_ready, bus.inst_valid, bus.inst_err,
           bus.pc, bus.inst, bus.fetch_cnt};
    exp = {4'b0000, RPC, 32'h0, 64'h0};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL mid_reset_async: got %h required %h", got, exp);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_pending = 1'b0;
    rsp_pct = 100;
    bus.inst_ready = 1'b0;
    cyc();
    n_vec++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RPC || bus.fetch_cnt !== 64'd0) begin
      n_err++;
      $display("FAIL mid_refetch: req=%b addr=%h cnt=%0d required 1 %h 0",
               bus.imem_req_valid, bus.imem_req_addr, bus.fetch_cnt, RPC);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [63:0] exp_cnt;
    logic [64:0] saved, exp_tx;
    logic        prev_stall;
    int          rc_mark, exp_reqs, quiet;
    reset_dut();
    req_pct = 60;
    rsp_pct = 50;
    proto_viol = 0;
    exp_pc = RPC;
    exp_cnt = 64'd0;
    rc_mark = req_count;
    prev_stall = 1'b0;
    saved = '0;
    quiet = 0;
    for (int cy = 0; cy < 3000; cy++) begin
      bus.inst_ready = ($urandom_range(99) < 60);
      case ($urandom_range(7))
        0:       bus.dnpc = RPC + {22'h0, 8'($urandom_range(255)), 2'b00} + 32'($urandom_range(3, 1));
        1, 2, 3: bus.dnpc = exp_pc + 32'h4;
        default: bus.dnpc = RPC + {22'h0, 8'($urandom_range(255)), 2'b00};
      endcase
      n_vec++;
      if (bus.fetch_cnt !== exp_cnt) begin
        n_err++;
        $display("FAIL rnd_cnt cy%0d: got %0d required %0d", cy, bus.fetch_cnt, exp_cnt);
      end
      if (bus.imem_req_valid) begin
        n_vec++;
        if (bus.imem_req_addr !== exp_pc || exp_pc[1:0] != 2'b00) begin
          n_err++;
          $display("FAIL rnd_req cy%0d: addr=%h required aligned %h", cy, bus.imem_req_addr, exp_pc);
        end
      end
      if (prev_stall) begin
        n_vec++;
        if ({bus.inst_valid, bus.pc, bus.inst, bus.inst_err} !== {1'b1, saved}) begin
          n_err++;
          $display("FAIL rnd_hold cy%0d: got %b %h required 1 %h",
                   cy, bus.inst_valid, {bus.pc, bus.inst, bus.inst_err}, saved);
        end
      end
      if (bus.inst_valid && bus.inst_ready) begin
        if (exp_pc[1:0] != 2'b00) begin
          exp_tx   = {exp_pc, 32'h0, 1'b1};
          exp_reqs = 0;
        end else begin
          exp_tx   = {exp_pc, mem_data(exp_pc), mem_err(exp_pc)};
          exp_reqs = 1;
        end
        n_vec++;
        if ({bus.pc, bus.inst, bus.inst_err} !== exp_tx || (req_count - rc_mark) != exp_reqs) begin
          n_err++;
          $display("FAIL rnd_accept cy%0d: got %h reqs=%0d required %h reqs=%0d",
                   cy, {bus.pc, bus.inst, bus.inst_err}, req_count - rc_mark, exp_tx, exp_reqs);
        end
        exp_pc  = bus.dnpc;
        exp_cnt = exp_cnt + 64'd1;
        rc_mark = req_count;
        quiet   = 0;
      end
      prev_stall = bus.inst_valid && !bus.inst_ready;
      saved      = {bus.pc, bus.inst, bus.inst_err};
      quiet++;
      if (quiet > 300) begin
        n_vec++;
        n_err++;
        $display("FAIL rnd_progress: no instruction accepted for %0d cycles", quiet);
        break;
      end
      cyc();
    end
    n_vec++;
    if (proto_viol != 0) begin
      n_err++;
      $display("FAIL rsp_outside_wait: %0d responses presented while rsp_ready=0, required 0", proto_viol);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_req_stall();
    test_inst_stall();
    test_err_rsp();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
